// File: rtl/i2c_master_byte.sv
// ---------------------------------------------------------------------------
// i2c_master_byte
//
// Single-byte I2C initiator. A one-cycle start pulse launches one transaction:
// START, 7-bit address + R/W, one data byte (written or read), STOP. SCL and
// SDA are open drain: *_oe = 1 pulls the pad low, 0 releases it. The slave may
// stretch SCL low during any bit's high phase.
//
// Parameters
//   CLK_DIV  system clocks per quarter SCL bit period (2..65535)
//
// Ports
//   clk, rst_n  system clock (rising edge), asynchronous active-low reset
//   start       one-cycle launch pulse, ignored while busy
//   rw          0 = write, 1 = read (sampled with start)
//   addr        7-bit slave address (sampled with start)
//   wdata       byte to write (sampled with start)
//   busy        transaction in progress
//   done        one-cycle completion pulse
//   ack_err     slave NACKed address or write data; held until next start
//   rdata       last byte read; held until the next read completes
//   scl_oe      1 = pull SCL low
//   sda_oe      1 = pull SDA low
//   scl_in      SCL pad level (clock-stretch detection)
//   sda_in      SDA pad level
// ---------------------------------------------------------------------------
module i2c_master_byte #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_ADDR     = 3'd2,
    ST_ADDR_ACK = 3'd3,
    ST_DATA     = 3'd4,
    ST_DATA_ACK = 3'd5,
    ST_STOP     = 3'd6
  } state_t;

  // Pad drive for a given state and quarter, returned as {scl_oe, sda_oe}.
  // sda_prev keeps SDA untouched in q0 of a bit so SDA only moves once SCL
  // has been low for a full quarter.
  function automatic logic [1:0] line_drive(input state_t     st,
                                            input logic [1:0] q,
                                            input logic       sda_prev,
                                            input logic       bit_low);
    logic [1:0] r;
    r = 2'b00;
    case (st)
      ST_START: begin
        case (q)
          2'd0:    r = 2'b00;
          2'd1:    r = 2'b01;
          2'd2:    r = 2'b01;
          2'd3:    r = 2'b11;
          default: r = 2'b00;
        endcase
      end
      ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK: begin
        case (q)
          2'd0:    r = {1'b1, sda_prev};
          2'd1:    r = {1'b1, bit_low};
          2'd2:    r = {1'b0, bit_low};
          2'd3:    r = {1'b0, bit_low};
          default: r = 2'b00;
        endcase
      end
      ST_STOP: begin
        case (q)
          2'd0:    r = 2'b11;
          2'd1:    r = 2'b01;
          2'd2:    r = 2'b01;
          2'd3:    r = 2'b00;
          default: r = 2'b00;
        endcase
      end
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  state_t      state_q,     state_d;
  logic [1:0]  q_q,         q_d;
  logic [15:0] div_q,       div_d;
  logic [2:0]  bit_cnt_q,   bit_cnt_d;
  logic [7:0]  addr_byte_q, addr_byte_d;   // {addr, rw}
  logic [7:0]  wdata_q,     wdata_d;
  logic [7:0]  shift_q,     shift_d;
  logic        samp_q,      samp_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        ack_err_q,   ack_err_d;
  logic [7:0]  rdata_q,     rdata_d;
  logic        scl_oe_q,    scl_oe_d;
  logic        sda_oe_q,    sda_oe_d;

  logic tick_s;
  logic bit_phase_s;
  logic stretch_s;
  logic bit_low_s;

  assign tick_s      = (div_q == DIV_MAX);
  assign bit_phase_s = (state_q == ST_ADDR) || (state_q == ST_ADDR_ACK) ||
                       (state_q == ST_DATA) || (state_q == ST_DATA_ACK);
  // The slave still holds SCL low at the end of a high quarter: freeze.
  assign stretch_s   = bit_phase_s && (q_q == 2'd2) && !scl_in;

  // Next-state: quarter sequencing, bit counting, SDA sampling, status.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    addr_byte_d = addr_byte_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ack_err_d   = ack_err_q;
    rdata_d     = rdata_q;

    if (state_q == ST_IDLE) begin
      div_d = 16'd0;
      q_d   = 2'd0;
      if (busy_q) begin
        // done cycle: busy is still visible, so a coincident start is ignored
        busy_d = 1'b0;
      end else if (start) begin
        addr_byte_d = {addr, rw};
        wdata_d     = wdata;
        ack_err_d   = 1'b0;
        busy_d      = 1'b1;
        bit_cnt_d   = 3'd7;
        state_d     = ST_START;
      end else begin
        busy_d = 1'b0;
      end
    end else if (tick_s) begin
      if (stretch_s) begin
        div_d = div_q;
      end else begin
        div_d = 16'd0;
        q_d   = q_q + 2'd1;
        case (q_q)
          2'd2: begin
            if (bit_phase_s) begin
              samp_d = sda_in;
            end else begin
              samp_d = samp_q;
            end
            if ((state_q == ST_DATA) && addr_byte_q[0]) begin
              shift_d = {shift_q[6:0], sda_in};
            end else begin
              shift_d = shift_q;
            end
          end
          2'd3: begin
            case (state_q)
              ST_START: begin
                bit_cnt_d = 3'd7;
                state_d   = ST_ADDR;
              end
              ST_ADDR: begin
                if (bit_cnt_q == 3'd0) begin
                  state_d = ST_ADDR_ACK;
                end else begin
                  bit_cnt_d = bit_cnt_q - 3'd1;
                end
              end
              ST_ADDR_ACK: begin
                if (samp_q) begin
                  ack_err_d = 1'b1;
                  state_d   = ST_STOP;
                end else begin
                  bit_cnt_d = 3'd7;
                  state_d   = ST_DATA;
                end
              end
              ST_DATA: begin
                if (bit_cnt_q == 3'd0) begin
                  state_d = ST_DATA_ACK;
                end else begin
                  bit_cnt_d = bit_cnt_q - 3'd1;
                end
              end
              ST_DATA_ACK: begin
                if (addr_byte_q[0]) begin
                  rdata_d = shift_q;
                end else begin
                  ack_err_d = ack_err_q | samp_q;
                end
                state_d = ST_STOP;
              end
              ST_STOP: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
              default: state_d = ST_IDLE;
            endcase
          end
          default: begin
            samp_d = samp_q;
          end
        endcase
      end
    end else begin
      div_d = div_q + 16'd1;
    end
  end

  // Pad drive derived from the next phase so the registered pins line up
  // exactly with the quarter boundaries.
  always_comb begin
    bit_low_s = 1'b0;
    case (state_d)
      ST_ADDR: bit_low_s = ~addr_byte_d[bit_cnt_d];
      ST_DATA: begin
        if (addr_byte_d[0]) begin
          bit_low_s = 1'b0;
        end else begin
          bit_low_s = ~wdata_d[bit_cnt_d];
        end
      end
      default: bit_low_s = 1'b0;
    endcase
    {scl_oe_d, sda_oe_d} = line_drive(state_d, q_d, sda_oe_q, bit_low_s);
  end

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      q_q         <= 2'd0;
      div_q       <= 16'd0;
      bit_cnt_q   <= 3'd0;
      addr_byte_q <= 8'h00;
      wdata_q     <= 8'h00;
      shift_q     <= 8'h00;
      samp_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      rdata_q     <= 8'h00;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_byte_q <= addr_byte_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      rdata_q     <= rdata_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;

endmodule
